if_axi_fetch: RTL and testbench

AXI4 read master that feeds the IF stage. It takes the fetch PC from the core, issues a single-beat read on the instruction-memory AXI port and returns the instruction word to the IF/ID pipeline register. While a fetch is outstanding it raises the instruction-memory stall, and it holds the delivered word while the core is stalled elsewhere. It also discards responses that belong to flushed fetches.

---
 rtl/if_axi_fetch_pkg.sv | 20 ++
 rtl/if_axi_fetch.sv | 114 +++++++++++
 tb/tb_if_axi_fetch.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_axi_fetch_pkg.sv
// rtl/if_axi_fetch_pkg.sv - shared types and AXI constants for the IF-stage fetch master
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package if_axi_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fetch_state_e;

    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [2:0]  SIZE_4B    = 3'b010;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [31:0] NOP_INSN   = `INST_NOP;

endpackage

// File: rtl/if_axi_fetch.sv
// rtl/if_axi_fetch.sv - single-outstanding AXI4 read master feeding the IF/ID register
module if_axi_fetch
    import if_axi_fetch_pkg::fetch_state_e, if_axi_fetch_pkg::IDLE, if_axi_fetch_pkg::ADDR,
           if_axi_fetch_pkg::DATA, if_axi_fetch_pkg::DONE, if_axi_fetch_pkg::BURST_INCR,
           if_axi_fetch_pkg::SIZE_4B, if_axi_fetch_pkg::RESP_OKAY;
#(
    parameter int               ID_W     = 4,
    parameter logic [ID_W-1:0]  AR_ID    = '0,
    parameter logic [31:0]      NOP_INSN = if_axi_fetch_pkg::NOP_INSN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_req_i,
    input  logic [31:0]      fetch_pc_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic [31:0]      insn_o,
    output logic             insn_valid_o,
    output logic             err_o,
    output logic             stall_axi_im_o,
    output logic [31:0]      araddr_o,
    output logic [ID_W-1:0]  arid_o,
    output logic [3:0]       arlen_o,
    output logic [2:0]       arsize_o,
    output logic [1:0]       arburst_o,
    output logic             arvalid_o,
    input  logic             arready_i,
    input  logic [ID_W-1:0]  rid_i,
    input  logic [31:0]      rdata_i,
    input  logic [1:0]       rresp_i,
    input  logic             rlast_i,
    input  logic             rvalid_i,
    output logic             rready_o
);

    fetch_state_e state;
    logic         drop;
    logic         r_hit;

    assign arid_o    = AR_ID;
    assign arlen_o   = 4'd0;
    assign arsize_o  = SIZE_4B;
    assign arburst_o = BURST_INCR;

    // Beats carrying a foreign id are accepted (rready stays high) but ignored.
    assign r_hit = rvalid_i && rlast_i && (rid_i == AR_ID);

    assign stall_axi_im_o = (fetch_req_i && state != DONE) || state == ADDR || state == DATA || drop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            drop         <= 1'b0;
            arvalid_o    <= 1'b0;
            rready_o     <= 1'b0;
            araddr_o     <= 32'd0;
            insn_o       <= NOP_INSN;
            insn_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        insn_o <= NOP_INSN;
                    end else if (fetch_req_i) begin
                        araddr_o  <= fetch_pc_i;
                        arvalid_o <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    // AR cannot be withdrawn once raised; a flush only marks the reply for discard.
                    if (flush_i) begin
                        drop <= 1'b1;
                    end
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (r_hit) begin
                        rready_o <= 1'b0;
                        if (drop || flush_i) begin
                            drop  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            insn_o       <= (rresp_i == RESP_OKAY) ? rdata_i : NOP_INSN;
                            err_o        <= (rresp_i != RESP_OKAY);
                            insn_valid_o <= 1'b1;
                            state        <= DONE;
                        end
                    end else if (flush_i) begin
                        drop <= 1'b1;
                    end
                end
                DONE: begin
                    err_o <= 1'b0;
                    if (flush_i) begin
                        insn_o       <= NOP_INSN;
                        insn_valid_o <= 1'b0;
                        state        <= IDLE;
                    end else if (!hold_i) begin
                        insn_valid_o <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_axi_fetch.sv
// tb/tb_if_axi_fetch.sv - randomized self-checking bench for if_axi_fetch
module tb_if_axi_fetch;

    localparam logic [3:0]  AR_ID = 4'h0;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i, fetch_req_i, flush_i, hold_i;
    logic [31:0] fetch_pc_i;
    logic [31:0] insn_o, araddr_o;
    logic        insn_valid_o, err_o, stall_axi_im_o, arvalid_o, arready_i, rready_o;
    logic [3:0]  arid_o, arlen_o, rid_i;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o, rresp_i;
    logic [31:0] rdata_i;
    logic        rlast_i, rvalid_i;

    always #5 clk_i = ~clk_i;

    if_axi_fetch #(.ID_W(4), .AR_ID(AR_ID), .NOP_INSN(NOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_req_i(fetch_req_i), .fetch_pc_i(fetch_pc_i),
        .flush_i(flush_i), .hold_i(hold_i), .insn_o(insn_o), .insn_valid_o(insn_valid_o),
        .err_o(err_o), .stall_axi_im_o(stall_axi_im_o), .araddr_o(araddr_o), .arid_o(arid_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arvalid_o(arvalid_o),
        .arready_i(arready_i), .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    int checks = 0;
    int failures = 0;
    int words_delivered = 0;

    // Transaction-level view of the fetcher: which phase of the one outstanding read is live.
    bit          m_ar_pending, m_r_pending, m_word_ready, m_discard, m_err;
    logic [31:0] m_addr, m_insn;

    // Memory-side responder.
    int          q_delay[$];
    logic [31:0] q_data[$];
    logic [1:0]  q_resp[$];
    bit          rand_mode = 1'b0;
    int          slave_dmax = 0;
    logic [31:0] next_rdata = 32'd0;
    logic [1:0]  next_rresp = 2'b00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ar_pending = 0; m_r_pending = 0; m_word_ready = 0; m_discard = 0; m_err = 0;
        m_addr = 32'd0; m_insn = NOP;
    endtask

    task automatic model_step();
        if (rst_i) begin
            model_reset();
        end else if (m_word_ready) begin
            m_err = 0;
            if (flush_i) begin
                m_word_ready = 0;
                m_insn = NOP;
            end else if (!hold_i) begin
                m_word_ready = 0;
                words_delivered++;
            end
        end else if (m_ar_pending) begin
            if (flush_i) m_discard = 1;
            if (arready_i) begin
                m_ar_pending = 0;
                m_r_pending = 1;
            end
        end else if (m_r_pending) begin
            if (rvalid_i && rlast_i && rid_i == AR_ID) begin
                m_r_pending = 0;
                if (m_discard || flush_i) begin
                    m_discard = 0;
                end else begin
                    m_word_ready = 1;
                    m_insn = (rresp_i == 2'b00) ? rdata_i : NOP;
                    m_err = (rresp_i != 2'b00);
                end
            end else if (flush_i) begin
                m_discard = 1;
            end
        end else begin
            if (flush_i) m_insn = NOP;
            else if (fetch_req_i) begin
                m_ar_pending = 1;
                m_addr = fetch_pc_i;
            end
        end
    endtask

    task automatic compare_regs();
        chk("arvalid", 32'(arvalid_o), 32'(m_ar_pending));
        chk("rready", 32'(rready_o), 32'(m_r_pending));
        chk("insn_valid", 32'(insn_valid_o), 32'(m_word_ready));
        chk("insn", insn_o, m_insn);
        chk("err", 32'(err_o), 32'(m_err));
        chk("araddr", araddr_o, m_addr);
        chk("ar_const", {arid_o, arlen_o, 1'b0, arsize_o, arburst_o}, {4'h0, 4'h0, 1'b0, 3'b010, 2'b01});
    endtask

    task automatic slave_update(input bit ar_hs, input bit r_hs, input bit r_match, input bit rs);
        if (rs) begin
            q_delay.delete(); q_data.delete(); q_resp.delete();
            rvalid_i = 0;
            return;
        end
        if (r_hs) begin
            if (r_match) begin
                void'(q_delay.pop_front()); void'(q_data.pop_front()); void'(q_resp.pop_front());
            end
            rvalid_i = 0;
        end
        if (ar_hs) begin
            q_data.push_back(rand_mode ? 32'($urandom) : next_rdata);
            q_resp.push_back(rand_mode ? (($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00) : next_rresp);
            q_delay.push_back(rand_mode ? int'($urandom_range(0, 3)) : slave_dmax);
        end
        if (!rvalid_i && q_delay.size() > 0) begin
            if (q_delay[0] == 0) begin
                rvalid_i = 1; rid_i = AR_ID; rdata_i = q_data[0]; rresp_i = q_resp[0];
            end else begin
                q_delay[0] = q_delay[0] - 1;
                if (rand_mode && rready_o && $urandom_range(0, 9) == 0) begin
                    rvalid_i = 1; rid_i = 4'h5; rdata_i = $urandom; rresp_i = 2'b00;
                end
            end
        end
    endtask

    // One clock: stall checked mid-cycle, handshakes sampled before the edge, registers after.
    task automatic tick();
        bit ar_hs, r_hs, r_match, rs;
        @(negedge clk_i);
        chk("stall", 32'(stall_axi_im_o),
            32'((fetch_req_i && !m_word_ready) || m_ar_pending || m_r_pending || m_discard));
        ar_hs = arvalid_o && arready_i;
        r_hs = rvalid_i && rready_o;
        r_match = (rid_i == AR_ID);
        rs = rst_i;
        model_step();
        @(posedge clk_i);
        #1;
        compare_regs();
        slave_update(ar_hs, r_hs, r_match, rs);
    endtask

    task automatic wait_valid(input string nm, input int bound);
        int n = 0;
        while (!insn_valid_o && n < bound) begin
            tick();
            n++;
        end
        chk(nm, 32'(insn_valid_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1; fetch_req_i = 0; fetch_pc_i = 0; flush_i = 0; hold_i = 0;
        arready_i = 0; rid_i = 0; rdata_i = 0; rresp_i = 0; rlast_i = 1; rvalid_i = 0;
        repeat (2) @(posedge clk_i);
        model_reset();
        #1;
        rst_i = 0;
        chk("rst_insn", insn_o, 32'h0000_0013);
        chk("rst_valid", 32'(insn_valid_o), 32'd0);
        chk("rst_arvalid", 32'(arvalid_o), 32'd0);
        chk("rst_araddr", araddr_o, 32'd0);

        // basic fetch, zero-wait slave
        fetch_req_i = 1; fetch_pc_i = 32'h100; arready_i = 1; next_rdata = 32'h0050_0093;
        tick();
        chk("t1_arvalid", 32'(arvalid_o), 32'd1);
        chk("t1_araddr", araddr_o, 32'h100);
        chk("t1_arlen", 32'(arlen_o), 32'd0);
        chk("t1_arsize", 32'(arsize_o), 32'd2);
        chk("t1_arburst", 32'(arburst_o), 32'd1);
        tick();
        chk("t1_not_yet", 32'(insn_valid_o), 32'd0);
        tick();
        chk("t1_valid", 32'(insn_valid_o), 32'd1);
        chk("t1_insn", insn_o, 32'h0050_0093);
        chk("t1_stall", 32'(stall_axi_im_o), 32'd0);
        fetch_req_i = 0;
        tick();

        // AR backpressure
        arready_i = 0; fetch_req_i = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_arvalid", 32'(arvalid_o), 32'd1);
            chk("t2_araddr", araddr_o, 32'h100);
            chk("t2_stall", 32'(stall_axi_im_o), 32'd1);
        end
        arready_i = 1;
        wait_valid("t2_timeout", 8);
        chk("t2_insn", insn_o, 32'h0050_0093);
        fetch_req_i = 0;
        tick();

        // flush after the AR handshake; the stale reply must be swallowed
        next_rdata = 32'hDEAD_BEEF; slave_dmax = 1; fetch_req_i = 1;
        tick();
        tick();
        flush_i = 1; fetch_pc_i = 32'h200;
        tick();
        chk("t3_valid_a", 32'(insn_valid_o), 32'd0);
        chk("t3_arvalid_a", 32'(arvalid_o), 32'd0);
        chk("t3_stall", 32'(stall_axi_im_o), 32'd1);
        flush_i = 0;
        tick();
        chk("t3_valid_b", 32'(insn_valid_o), 32'd0);
        chk("t3_arvalid_b", 32'(arvalid_o), 32'd0);
        next_rdata = 32'h00A0_0113; slave_dmax = 0;
        tick();
        chk("t3_arvalid_c", 32'(arvalid_o), 32'd1);
        chk("t3_araddr", araddr_o, 32'h200);
        wait_valid("t3_timeout", 8);
        chk("t3_insn", insn_o, 32'h00A0_0113);
        fetch_req_i = 0;
        tick();

        // hold in DONE
        fetch_req_i = 1; fetch_pc_i = 32'h300; next_rdata = 32'h0100_0193;
        wait_valid("t4_timeout", 8);
        hold_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_valid", 32'(insn_valid_o), 32'd1);
            chk("t4_insn", insn_o, 32'h0100_0193);
            chk("t4_arvalid", 32'(arvalid_o), 32'd0);
        end
        hold_i = 0; fetch_req_i = 0;
        tick();
        chk("t4_released", 32'(insn_valid_o), 32'd0);

        // SLVERR
        fetch_req_i = 1; fetch_pc_i = 32'h400; next_rdata = 32'h1234_5678; next_rresp = 2'b10;
        wait_valid("t5_timeout", 8);
        chk("t5_insn", insn_o, 32'h0000_0013);
        chk("t5_err", 32'(err_o), 32'd1);
        hold_i = 1;
        tick();
        chk("t5_err_pulse", 32'(err_o), 32'd0);
        chk("t5_valid", 32'(insn_valid_o), 32'd1);
        hold_i = 0; fetch_req_i = 0; next_rresp = 2'b00;
        tick();

        // reset while the AR is waiting
        arready_i = 0; fetch_req_i = 1; fetch_pc_i = 32'h500;
        tick();
        chk("t6_arvalid_pre", 32'(arvalid_o), 32'd1);
        rst_i = 1;
        tick();
        rst_i = 0;
        chk("t6_arvalid", 32'(arvalid_o), 32'd0);
        chk("t6_insn", insn_o, 32'h0000_0013);
        chk("t6_valid", 32'(insn_valid_o), 32'd0);
        arready_i = 1;
        wait_valid("t6_timeout", 8);
        chk("t6_insn_after", insn_o, 32'h1234_5678);
        fetch_req_i = 0;
        tick();

        // randomized traffic
        rand_mode = 1;
        words_delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!m_ar_pending && !m_r_pending && !m_word_ready && !m_discard) begin
                fetch_req_i = ($urandom_range(0, 9) < 7);
                fetch_pc_i = 32'($urandom) & 32'hFFFF_FFFC;
            end else begin
                fetch_req_i = ($urandom_range(0, 9) < 8);
            end
            rst_i = ($urandom_range(0, 199) == 0);
            flush_i = ($urandom_range(0, 15) == 0);
            hold_i = ($urandom_range(0, 9) < 4);
            arready_i = 1'($urandom_range(0, 1));
            tick();
        end
        rst_i = 0; flush_i = 0; hold_i = 0;
        chk("rand_words_delivered", 32'(words_delivered > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
